// File: rtl/dst_drain_pkg.sv
// Shared types and constants for the destination-buffer drain engine.
// Optional ReLU clamp selected by DST_DRAIN_RELU_EN (see dst_drain.sv).
package dst_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam int PAIR_AW  = 11;
  localparam int BANK_BIT = 12;

  typedef struct {
    real d0;
    real d1;
  } pair_t;

  // Negative words clamp to zero; zero and positives are untouched.
  function automatic real relu_word(input real x);
    return (x < 0.0) ? 0.0 : x;
  endfunction

endpackage

// File: rtl/dst_drain_fifo.sv
// Small pair FIFO used as the output skid buffer of dst_drain.
// Supports push and pop in the same cycle with occupancy unchanged.
module dst_drain_fifo
  import dst_drain_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  real           push_d0,
  input  real           push_d1,
  input  logic          pop,
  output logic          valid,
  output real           pop_d0,
  output real           pop_d1,
  output logic [CW-1:0] count
);

  pair_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic push_ok;
  logic pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid   = (count != '0);
  assign pop_ok  = pop & valid;
  assign push_ok = push & ((count != CW'(DEPTH)) | pop_ok);

  // Head data reads as zero when empty so idle outputs stay at 0.0.
  assign pop_d0 = valid ? mem[rd_ptr].d0 : 0.0;
  assign pop_d1 = valid ? mem[rd_ptr].d1 : 0.0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].d0 <= 0.0;
        mem[i].d1 <= 0.0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr].d0 <= push_d0;
        mem[wr_ptr].d1 <= push_d1;
        wr_ptr         <= next_ptr(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dst_drain.sv
// Streams a contiguous pair range of one dst_buf bank out on valid/ready.
// Define DST_DRAIN_RELU_EN to add the 'relu' port that clamps negative words.
module dst_drain
  import dst_drain_pkg::*;
#(
  parameter int CNT_W      = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bank,
  input  logic [10:0]      base,
  input  logic [CNT_W-1:0] count,
  input  logic             acc_busy,
`ifdef DST_DRAIN_RELU_EN
  input  logic             relu,
`endif
  output logic             busy,
  output logic             done,
  output logic             dst_v,
  output logic [12:0]      dst_a,
  input  real              dst_d0,
  input  real              dst_d1,
  output logic             m_valid,
  input  logic             m_ready,
  output real              m_d0,
  output real              m_d1,
  output logic             m_last
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_FIN   = FIN;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]         state;
  logic               lat_bank;
  logic [PAIR_AW-1:0] lat_base;
  logic [CNT_W-1:0]   lat_count;
  logic [CNT_W-1:0]   issued;
  logic [CNT_W-1:0]   beats;
  logic               inflight;
  logic [FCW-1:0]     fifo_count;
  logic [FCW:0]       credit_used;
  logic               issue;
  logic               last_issue;
  logic               pop;
  logic               last_pop;
  real                push_d0;
  real                push_d1;
`ifdef DST_DRAIN_RELU_EN
  logic               lat_relu;
`endif

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);
  assign pop  = m_valid & m_ready;

  // A beat leaving the FIFO this cycle frees its slot, which keeps a
  // two-entry FIFO streaming at one pair per cycle.
  assign credit_used = {1'b0, fifo_count} + (FCW+1)'(inflight) - (FCW+1)'(pop);

  assign issue = (state == S_RUN) & ~acc_busy & (issued < lat_count) &
                 (credit_used < (FCW+1)'(FIFO_DEPTH));
  assign last_issue = issue & (issued == lat_count - CNT_W'(1));
  assign last_pop   = pop & (beats == lat_count - CNT_W'(1));
  assign m_last     = m_valid & (beats == lat_count - CNT_W'(1));
  assign dst_v      = issue;

  // Bank bit is held for the whole busy period so the buffer mux stays put
  // through the capture cycle of the final read.
  always_comb begin
    dst_a = '0;
    if (busy) begin
      dst_a[BANK_BIT]    = lat_bank;
      dst_a[PAIR_AW-1:0] = lat_base + issued[PAIR_AW-1:0];
    end
  end

`ifdef DST_DRAIN_RELU_EN
  assign push_d0 = lat_relu ? relu_word(dst_d0) : dst_d0;
  assign push_d1 = lat_relu ? relu_word(dst_d1) : dst_d1;
`else
  assign push_d0 = dst_d0;
  assign push_d1 = dst_d1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      lat_bank  <= 1'b0;
      lat_base  <= '0;
      lat_count <= '0;
      issued    <= '0;
      beats     <= '0;
      inflight  <= 1'b0;
`ifdef DST_DRAIN_RELU_EN
      lat_relu  <= 1'b0;
`endif
    end else begin
      inflight <= issue;
      if (issue) issued <= issued + CNT_W'(1);
      if (pop)   beats  <= beats + CNT_W'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            lat_bank  <= bank;
            lat_base  <= base;
            lat_count <= count;
            issued    <= '0;
            beats     <= '0;
`ifdef DST_DRAIN_RELU_EN
            lat_relu  <= relu;
`endif
            state     <= (count == '0) ? S_FIN : S_RUN;
          end
        end
        S_RUN:   if (last_issue) state <= S_DRAIN;
        S_DRAIN: if (last_pop)   state <= S_FIN;
        default: state <= S_IDLE;
      endcase
    end
  end

  dst_drain_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (inflight),
    .push_d0 (push_d0),
    .push_d1 (push_d1),
    .pop     (pop),
    .valid   (m_valid),
    .pop_d0  (m_d0),
    .pop_d1  (m_d1),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_dst_drain.sv
// Self-checking bench for dst_drain: dst_buf model, beat scoreboard, directed tests.
// Define DST_DRAIN_RELU_EN to also exercise the ReLU clamp.
module tb_dst_drain;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        bank;
  logic [10:0] base;
  logic [11:0] count;
  logic        acc_busy;
  logic        busy, done, dst_v, m_valid, m_ready, m_last;
  logic [12:0] dst_a;
  real         dst_d0, dst_d1, m_d0, m_d1;
`ifdef DST_DRAIN_RELU_EN
  logic        relu;
`endif

  typedef struct {
    real d0;
    real d1;
    bit  last;
  } beat_t;

  real    mem [0:1][0:4095];
  logic   rd_pend;
  logic [10:0] rd_pair;
  int     tests = 0;
  int     fails = 0;
  beat_t  expq [$];
  real    log_d0 [$];
  real    log_d1 [$];
  int     log_addr [$];
  bit     chk_en = 0, last_hs_prev = 0, zero_pend = 0, rmode = 0, relu_on = 0;
  bit     pop_now, hs_last;
  int     issues, pops, xbase, xcount, exp_addr;
  logic   xb;
  int     cyc, fv;

  dst_drain #(.CNT_W(12), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bank     (bank),
    .base     (base),
    .count    (count),
    .acc_busy (acc_busy),
`ifdef DST_DRAIN_RELU_EN
    .relu     (relu),
`endif
    .busy     (busy),
    .done     (done),
    .dst_v    (dst_v),
    .dst_a    (dst_a),
    .dst_d0   (dst_d0),
    .dst_d1   (dst_d1),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_d0     (m_d0),
    .m_d1     (m_d1),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  // dst_buf model: address registered on the strobe, bank mux applied in
  // the data cycle; junk is driven whenever no read is returning.
  always @(posedge clk) begin
    rd_pend <= dst_v;
    rd_pair <= dst_a[10:0];
  end

  always_comb begin
    dst_d0 = -999.0;
    dst_d1 = -999.0;
    if (rd_pend) begin
      dst_d0 = mem[dst_a[12]][{rd_pair, 1'b0}];
      dst_d1 = mem[dst_a[12]][{rd_pair, 1'b1}];
    end
  end

  initial begin
    int k;
    k = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode) begin
        m_ready = (k % 3 == 0);
        k++;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  task automatic check_bit(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_real(input string name, input real act, input real req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %f, expected %f at %0t", name, act, req, $time);
    end
  endtask

  function automatic real model_word(input real v, input bit r);
    return (r && v < 0.0) ? 0.0 : v;
  endfunction

  // Per-cycle compare against the scoreboard and the issue rules.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      pop_now = m_valid && m_ready;
      hs_last = 1'b0;
      check_bit("done", done, last_hs_prev || zero_pend);
      zero_pend = 1'b0;
      if (dst_v) begin
        check_bit("issue_acc_busy", acc_busy, 0);
        check_bit("issue_credit", (issues - pops - int'(pop_now)) < DEPTH, 1);
        check_bit("issue_range", issues < xcount, 1);
        exp_addr = (xbase + issues) % 2048;
        check_bit("dst_a", dst_a, {xb, 1'b0, 11'(exp_addr)});
        log_addr.push_back(int'(dst_a[10:0]));
        issues++;
      end
      if (busy) check_bit("dst_a_bank", dst_a[12], xb);
      if (m_valid) begin
        if (expq.size() == 0) begin
          check_bit("extra_beat", 1, 0);
        end else begin
          check_real("m_d0", m_d0, expq[0].d0);
          check_real("m_d1", m_d1, expq[0].d1);
          check_bit("m_last", m_last, expq[0].last);
          if (pop_now) begin
            hs_last = expq[0].last;
            log_d0.push_back(m_d0);
            log_d1.push_back(m_d1);
            void'(expq.pop_front());
            pops++;
          end
        end
      end
      last_hs_prev = hs_last;
    end
  end

  task automatic start_xfer(input logic b, input int bs, input int cnt, input bit r);
    bit accepted;
    int pair;
    beat_t bt;
    @(posedge clk);
    #1;
    bank  = b;
    base  = 11'(bs);
    count = 12'(cnt);
    start = 1'b1;
`ifdef DST_DRAIN_RELU_EN
    relu  = r;
`endif
    accepted = !busy;
    if (accepted) begin
      xb = b; xbase = bs; xcount = cnt; issues = 0; pops = 0; relu_on = r;
      log_d0.delete(); log_d1.delete(); log_addr.delete();
      for (int i = 0; i < cnt; i++) begin
        pair    = (bs + i) % 2048;
        bt.d0   = model_word(mem[b][2*pair], relu_on);
        bt.d1   = model_word(mem[b][2*pair+1], relu_on);
        bt.last = (i == cnt - 1);
        expq.push_back(bt);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    if (accepted && cnt == 0) zero_pend = 1'b1;
  endtask

  task automatic wait_done(input int max, output int done_cyc, output int valid_cyc);
    done_cyc  = -1;
    valid_cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (m_valid && valid_cyc < 0) valid_cyc = i;
      if (done) begin
        done_cyc = i;
        break;
      end
    end
    if (done_cyc < 0) check_bit("done_timeout", 0, 1);
    check_bit("beats_left", expq.size(), 0);
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 4096; k++)
        mem[b][k] = b * 10000.0 + k;
    reset = 1'b1; start = 1'b0; bank = 1'b0; base = '0; count = '0; acc_busy = 1'b0;
`ifdef DST_DRAIN_RELU_EN
    relu = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_bit("rst_busy", busy, 0);
    check_bit("rst_done", done, 0);
    check_bit("rst_dst_v", dst_v, 0);
    check_bit("rst_dst_a", dst_a, 0);
    check_bit("rst_m_valid", m_valid, 0);
    check_bit("rst_m_last", m_last, 0);
    check_real("rst_m_d0", m_d0, 0.0);
    reset = 1'b0;
    chk_en = 1'b1;

    // Basic stream: four beats, first valid on cycle 3, done on cycle 7.
    start_xfer(1'b0, 0, 4, 1'b0);
    wait_done(30, cyc, fv);
    check_bit("t1_first_valid", fv, 3);
    check_bit("t1_done_cycle", cyc, 7);
    check_bit("t1_beats", log_d0.size(), 4);
    check_real("t1_b0_d0", log_d0[0], 0.0);
    check_real("t1_b0_d1", log_d1[0], 1.0);
    check_real("t1_b3_d0", log_d0[3], 6.0);
    check_real("t1_b3_d1", log_d1[3], 7.0);

    // Address wrap in bank 1.
    start_xfer(1'b1, 2046, 3, 1'b0);
    wait_done(30, cyc, fv);
    check_bit("t2_addrs", log_addr.size(), 3);
    check_bit("t2_addr0", log_addr[0], 2046);
    check_bit("t2_addr1", log_addr[1], 2047);
    check_bit("t2_addr2", log_addr[2], 0);
    check_real("t2_b0_d0", log_d0[0], 14092.0);
    check_real("t2_b1_d1", log_d1[1], 14095.0);
    check_real("t2_b2_d0", log_d0[2], 10000.0);

    // Backpressure with m_ready cycling 1,0,0.
    rmode = 1'b1;
    start_xfer(1'b0, 100, 8, 1'b0);
    wait_done(100, cyc, fv);
    rmode = 1'b0;
    check_bit("t3_beats", log_d0.size(), 8);
    check_real("t3_b7_d0", log_d0[7], 214.0);
    check_real("t3_b7_d1", log_d1[7], 215.0);

    // acc_busy stall for five cycles mid-transfer.
    start_xfer(1'b1, 500, 10, 1'b0);
    repeat (3) @(posedge clk);
    #1 acc_busy = 1'b1;
    repeat (5) @(posedge clk);
    #1 acc_busy = 1'b0;
    wait_done(60, cyc, fv);
    check_bit("t4_done_cycle", cyc, 10);
    check_bit("t4_beats", log_d0.size(), 10);
    check_real("t4_b9_d1", log_d1[9], 11019.0);

    // Zero-length transfer.
    start_xfer(1'b0, 5, 0, 1'b0);
    wait_done(5, cyc, fv);
    check_bit("t5_done_cycle", cyc, 1);
    check_bit("t5_no_valid", fv, -1);

    // A start while busy is ignored.
    start_xfer(1'b1, 10, 6, 1'b0);
    #1 start = 1'b1; bank = 1'b0; base = 11'd700; count = 12'd2;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(40, cyc, fv);
    check_bit("t6_beats", log_d0.size(), 6);
    check_real("t6_b5_d1", log_d1[5], 10031.0);

    // Reset in the middle of a six-beat stream.
    start_xfer(1'b0, 40, 6, 1'b0);
    for (int i = 0; i < 20 && pops < 2; i++) @(negedge clk);
    check_bit("t7_reached_beat2", pops >= 2, 1);
    @(posedge clk);
    #1 chk_en = 1'b0;
    reset = 1'b1;
    #1;
    check_bit("t7_busy", busy, 0);
    check_bit("t7_dst_v", dst_v, 0);
    check_bit("t7_dst_a", dst_a, 0);
    check_bit("t7_m_valid", m_valid, 0);
    check_bit("t7_m_last", m_last, 0);
    check_real("t7_m_d1", m_d1, 0.0);
    @(posedge clk);
    #1 reset = 1'b0;
    expq.delete();
    last_hs_prev = 1'b0;
    zero_pend = 1'b0;
    chk_en = 1'b1;
    start_xfer(1'b0, 0, 2, 1'b0);
    wait_done(20, cyc, fv);
    check_bit("t8_done_cycle", cyc, 5);
    check_real("t8_b1_d0", log_d0[1], 2.0);

`ifdef DST_DRAIN_RELU_EN
    mem[0][600] = -1.5;
    mem[0][601] = 2.0;
    start_xfer(1'b0, 300, 1, 1'b1);
    wait_done(20, cyc, fv);
    check_real("relu_on_d0", log_d0[0], 0.0);
    check_real("relu_on_d1", log_d1[0], 2.0);
    start_xfer(1'b0, 300, 1, 1'b0);
    wait_done(20, cyc, fv);
    check_real("relu_off_d0", log_d0[0], -1.5);
    check_real("relu_off_d1", log_d1[0], 2.0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
